// File: rtl/reg_dump_streamer_if.sv
// Indexed word stream carrying dumped register contents.
// The master presents valid/data/index and the slave returns ready.
interface reg_dump_streamer_if #(
  parameter int AW = 5,
  parameter int DW = 32
) ();
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_index;

  modport master (output out_valid, output out_data, output out_index, input out_ready);
  modport slave  (input out_valid, input out_data, input out_index, output out_ready);
endinterface

// File: rtl/reg_dump_streamer.sv
// Walks reg_file through its two read ports as even/odd pairs and streams each
// register out as an indexed word with a valid/ready handshake.
module reg_dump_streamer #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [AW-1:0]       addreg1,
  output logic [AW-1:0]       addreg2,
  input  logic [DW-1:0]       doutreg1,
  input  logic [DW-1:0]       doutreg2,
  reg_dump_streamer_if.master out_if
);
  localparam int NPAIRS = NREGS / 2;
  localparam int KW     = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(NPAIRS - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND0, S_SEND1, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [DW-1:0] buf0_q, buf0_d;
  logic [DW-1:0] buf1_q, buf1_d;
  logic [DW-1:0] last_data_q, last_data_d;
  logic [AW-1:0] last_index_q, last_index_d;
  logic          hs;

  assign addreg1 = AW'(k_q) << 1;
  assign addreg2 = addreg1 | AW'(1);
  assign hs      = out_if.out_valid && out_if.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      last_data_q  <= '0;
      last_index_q <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      last_data_q  <= last_data_d;
      last_index_q <= last_index_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;
    last_data_d  = last_data_q;
    last_index_d = last_index_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          k_d     = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // Both words latch on the same edge so a pair is never torn by a write.
        buf0_d  = doutreg1;
        buf1_d  = doutreg2;
        state_d = S_SEND0;
      end
      S_SEND0: begin
        if (hs) begin
          last_data_d  = buf0_q;
          last_index_d = addreg1;
          state_d      = S_SEND1;
        end
      end
      S_SEND1: begin
        if (hs) begin
          last_data_d  = buf1_q;
          last_index_d = addreg2;
          if (k_q == LAST_K) begin
            state_d = S_DONE;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outside the SEND states the stream keeps showing the last accepted word.
  always_comb begin
    busy              = (state_q != S_IDLE);
    done              = (state_q == S_DONE);
    out_if.out_valid  = 1'b0;
    out_if.out_data   = last_data_q;
    out_if.out_index  = last_index_q;
    case (state_q)
      S_SEND0: begin
        out_if.out_valid = 1'b1;
        out_if.out_data  = buf0_q;
        out_if.out_index = addreg1;
      end
      S_SEND1: begin
        out_if.out_valid = 1'b1;
        out_if.out_data  = buf1_q;
        out_if.out_index = addreg2;
      end
      default: ;
    endcase
  end
endmodule

// File: doc/reg_dump_streamer.md
# reg_dump_streamer

Sequential register-file reader that walks all architectural registers of `reg_file` through its two asynchronous read ports and streams their contents out as an indexed word stream with valid/ready handshake. It sits beside `reg_file` as the read-side counterpart of the write port and feeds debug and trace logic, such as end-of-program state dumps and a UART or trace formatter. Registers are fetched as even/odd pairs in one cycle, buffered, then emitted one word per handshake.

## Interface
- `NREGS`, default 32: number of registers to dump; must be even and ≥2.
- `AW`, default 5: register address width; must satisfy 2^AW ≥ NREGS.
- `DW`, default 32: register data width.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a full dump; sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last word is accepted.
- `addreg1` out AW: read address to `reg_file` port 1 (even register).
- `addreg2` out AW: read address to `reg_file` port 2 (odd register).
- `doutreg1` in DW: `reg_file` read data 1 (combinational read).
- `doutreg2` in DW: `reg_file` read data 2 (combinational read).
- `out_valid` out 1: stream word valid.
- `out_ready` in 1: downstream accepts the word.
- `out_data` out DW: register contents.
- `out_index` out AW: register number of `out_data`.

## Operation
- Pair counter `k`, range 0..NREGS/2−1. `addreg1 = 2k` and `addreg2 = 2k+1` at all times, decoded from `k`.
- Two-entry buffer: `buf0` and `buf1`, each DW wide.
- FSM states are IDLE, FETCH, SEND0, SEND1 and DONE.
  - IDLE: if `start` is high, set `k` to 0 and go to FETCH. Otherwise stay in IDLE.
  - FETCH: load `buf0` from `doutreg1` and `buf1` from `doutreg2`, then go to SEND0. Both words of a pair are captured at the same edge, so each pair is an atomic snapshot.
  - SEND0: `out_valid` = 1, `out_data` = `buf0`, `out_index` = 2k. On `out_valid && out_ready`, go to SEND1.
  - SEND1: `out_valid` = 1, `out_data` = `buf1`, `out_index` = 2k+1. On handshake:
    - if k = NREGS/2−1, go to DONE;
    - otherwise increment `k` and go to FETCH.
  - DONE: `done` = 1 for exactly one cycle, then go to IDLE.
- Handshake rules:
  - While `out_valid` is high and `out_ready` is low, `out_data` and `out_index` hold stable.
  - `out_valid` never drops without a handshake, except on `rst`.
- `start` is ignored outside IDLE; it does not queue.
- Writes to `reg_file` during a dump are allowed:
  - a pair not yet fetched reflects the write;
  - a pair already fetched does not;
  - no tearing occurs within a pair.
- `out_data` and `out_index` hold the last emitted value outside SEND states; only `out_valid` qualifies them.

## Timing
- Reset values: state = IDLE, `k` = 0, `buf0` = `buf1` = 0, `busy` = 0, `done` = 0, `out_valid` = 0, `out_data` = 0, `out_index` = 0, `addreg1` = 0, `addreg2` = 1.
- `rst` high at any edge, including mid-dump: return to IDLE at that edge. `out_valid` is low in the next cycle and no `done` pulse is issued. `rst` has priority over `start`.
- Cycle numbering: `start` is sampled high at edge 0.
  - FETCH is in cycle 1 and `busy` rises in cycle 1.
  - The first `out_valid` is in cycle 2.
- With `out_ready` held high, each pair takes 3 cycles (FETCH, SEND0, SEND1). Index NREGS−1 is presented in cycle 3·NREGS/2.
  - `done` is high in cycle 3·NREGS/2+1 (cycle 49 at the defaults).
  - IDLE resumes in the next cycle (cycle 50 at the defaults); `busy` is low there.
- Each cycle of backpressure in SEND0 or SEND1 adds exactly one cycle.
- A `start` held high through the DONE cycle begins a new dump: FETCH follows the first IDLE cycle.

## Test plan
- Full dump with `out_ready` = 1: preload reg r = r·1000 and r1 = 1234.
  - Expect 32 words, index 0..31 in order, with `out_data` = index·1000, except index 1 = 1234.
  - `done` pulses in cycle 49; `busy` is high in cycles 1–49.
- Backpressure: hold `out_ready` low for 3 cycles while index 5 is presented.
  - `out_data` and `out_index` stay at reg 5 / 5 with `out_valid` high.
  - Completion shifts by exactly 3 cycles.
- `start` re-asserted in cycles 2–10 of a dump: no restart, and the stream is unchanged.
- Reset mid-dump: assert `rst` while index 10 is valid.
  - Next cycle: `out_valid` = 0, `busy` = 0, no `done`.
  - A new `start` dumps from index 0.
- Concurrent write: during SEND0 of pair k = 3, write reg 7 = 0xDEAD and reg 8 = 0xBEEF.
  - Index 7 shows the old value.
  - Index 8 shows 0xBEEF.
